// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM encoding and a
// width helper for the slice index.
package adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Ceiling log2 with a floor of one bit, so a single-slice build still
    // has a real index register.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational WIDTH-bit ripple adder with carry in and carry out.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the top carry lands in cout.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-precision adder: walks CHUNKS slices of WIDTH bits through one
// full_adder, least-significant slice first, with the carry registered
// between slices. Valid/ready handshakes on both the operand and result side.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   in_a,
    input  logic [WIDTH*CHUNKS-1:0]   in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      busy
);

    localparam int TW    = WIDTH * CHUNKS;
    localparam int IDX_W = clog2(CHUNKS);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [TW-1:0]     a_q, a_d;
    logic [TW-1:0]     b_q, b_d;
    logic [TW-1:0]     sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]  fa_a;
    logic [WIDTH-1:0]  fa_b;
    logic [WIDTH-1:0]  fa_sum;
    logic              fa_cout;
    logic              last_slice;

    assign last_slice = (idx_q == IDX_W'(CHUNKS - 1));

    // Slice mux: present the current slice of each captured operand.
    always_comb begin
        fa_a = '0;
        fa_b = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                fa_a = a_q[i*WIDTH +: WIDTH];
                fa_b = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    full_adder #(.WIDTH(WIDTH)) u_full_adder (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through slices in RUN,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
    end

    // Datapath next values: operand capture, per-slice sum write-back,
    // carry chaining and final carry-out latch.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                for (int i = 0; i < CHUNKS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*WIDTH +: WIDTH] = fa_sum;
                    end
                end
                carry_d = fa_cout;
                if (last_slice) begin
                    cout_d = fa_cout;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; result stays put in IDLE until the next run or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: a 4x4-bit build and a 1x4-bit build.
module tb_chunked_serial_adder;

    logic clk;
    logic rst;

    // 16-bit build (WIDTH=4, CHUNKS=4)
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [15:0] in_a, in_b, out_sum;

    // 4-bit single-slice build (WIDTH=4, CHUNKS=1)
    logic        s_in_valid, s_in_ready, s_in_cin, s_out_valid, s_out_ready, s_out_cout, s_busy;
    logic [3:0]  s_in_a, s_in_b, s_out_sum;

    int total;
    int bad;

    chunked_serial_adder #(.WIDTH(4), .CHUNKS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    chunked_serial_adder #(.WIDTH(4), .CHUNKS(1)) dut_one (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .in_cin    (s_in_cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_cout  (s_out_cout),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n = n + 1;
        end
    endtask

    // Full transaction on the 16-bit build with handshake at the end.
    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n = n + 1;
        end
        chk_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_val({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk_val({tag, "_latency"}, 32'(n), 32'd4);
        chk_val({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        chk_val({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
        $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d",
                 tag, a, b, cin, out_sum, out_cout, n);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_val({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk_val({tag, "_held"}, 32'(out_sum), 32'(exp_sum));
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_out_ready = 1'b0;

        // Reset state
        #2;
        chk_val("rst_in_ready", 32'(in_ready), 32'd1);
        chk_val("rst_out_valid", 32'(out_valid), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk_val("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk_val("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk_val("post_rst_sum", 32'(out_sum), 32'd0);
        chk_val("post_rst_cout", 32'(out_cout), 32'd0);
        chk_val("post_rst_busy", 32'(busy), 32'd0);

        // Main function
        run_txn("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        run_txn("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_txn("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure: result must hold while new operands wait outside
        in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_done(n);
        chk_val("bp_latency", 32'(n), 32'd4);
        in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_val("bp_out_valid", 32'(out_valid), 32'd1);
            chk_val("bp_sum", 32'(out_sum), 32'h2345);
            chk_val("bp_cout", 32'(out_cout), 32'd0);
            chk_val("bp_in_ready", 32'(in_ready), 32'd0);
        end
        $display("txn backpressure: held sum=%h for 5 cycles", out_sum);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_val("bp_release_idle", 32'(in_ready), 32'd1);
        chk_val("bp_release_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk_val("bp_accepted", 32'(busy), 32'd1);
        wait_done(n);
        chk_val("bp2_latency", 32'(n), 32'd4);
        chk_val("bp2_sum", 32'(out_sum), 32'h1011);
        chk_val("bp2_cout", 32'(out_cout), 32'd0);
        $display("txn queued: a=0f0f b=0101 cin=1 -> sum=%h cout=%0d", out_sum, out_cout);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset two cycles into RUN
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk_val("mid_rst_sum", 32'(out_sum), 32'd0);
        chk_val("mid_rst_cout", 32'(out_cout), 32'd0);
        chk_val("mid_rst_busy", 32'(busy), 32'd0);
        $display("txn reset_mid_run: sum=%h busy=%0d", out_sum, busy);
        step();
        rst = 1'b0;
        step();
        chk_val("after_rst_valid", 32'(out_valid), 32'd0);
        run_txn("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // Single-slice build
        chk_val("one_in_ready", 32'(s_in_ready), 32'd1);
        s_in_a = 4'hF; s_in_b = 4'h1; s_in_cin = 1'b1; s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            step();
            n = n + 1;
        end
        chk_val("one_latency", 32'(n), 32'd1);
        chk_val("one_sum", 32'(s_out_sum), 32'h1);
        chk_val("one_cout", 32'(s_out_cout), 32'd1);
        $display("txn one_slice: a=f b=1 cin=1 -> sum=%h cout=%0d latency=%0d",
                 s_out_sum, s_out_cout, n);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        chk_val("one_idle", 32'(s_in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Sequential multi-precision adder for operands wider than one full_adder. It splits each operand into CHUNKS slices of WIDTH bits and feeds them to a single full_adder instance, least-significant slice first, one slice per clock. Carry is registered between slices. Sits upstream of the full_adder and drives it; presents a valid/ready stream interface on both sides.

Parameters:
WIDTH, 4, bit width of one slice; also the WIDTH of the full_adder instance.
CHUNKS, 4, number of slices; total operand width TW = WIDTH*CHUNKS; CHUNKS >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands; high only in IDLE
in_a  input  TW  operand A
in_b  input  TW  operand B
in_cin  input  1  carry into slice 0
out_valid  output  1  result available; high only in DONE
out_ready  input  1  consumer accepts result
out_sum  output  TW  registered result
out_cout  output  1  carry out of top slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, carry_q=0, result reg=0, operand regs=0.
- Output values while rst=1 and immediately after it releases: in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
- States: IDLE=0, RUN=1, DONE=2. The unused encoding returns to IDLE.
- IDLE: in_ready=1.
  - On in_valid&in_ready at edge E0: capture in_a, in_b, carry_q<=in_cin, idx<=0, go to RUN.
  - in_valid low: stay in IDLE.
- RUN: in_ready=0.
  - full_adder inputs: a=A[idx*WIDTH +: WIDTH], b=B[idx*WIDTH +: WIDTH], cin=carry_q.
  - Each edge: result slice idx<=sum, carry_q<=cout, idx<=idx+1.
  - At the edge where idx==CHUNKS-1: out_cout<=cout, idx<=0, go to DONE.
- Latency: out_valid rises CHUNKS edges after E0.
  - CHUNKS=1: exactly one RUN cycle.
- DONE: out_valid=1. out_sum and out_cout are held stable until out_valid&out_ready, then go to IDLE.
  - out_sum and out_cout keep their last value in IDLE. They are cleared only by reset.
- Throughput: one transaction per CHUNKS+2 cycles minimum. There is no accept in the same cycle as result handoff.
- in_a, in_b and in_cin are ignored outside the accepting edge. Changes during RUN or DONE have no effect.
- in_valid held high while not ready: no capture. The transaction is accepted on the first cycle back in IDLE.
- Arithmetic: modulo 2^TW plus out_cout. {out_cout,out_sum} == in_a+in_b+in_cin exactly.
- idx width is clog2(CHUNKS), minimum 1 bit. idx never exceeds CHUNKS-1.
- Reset mid-RUN or mid-DONE: the transaction is discarded and all outputs return to reset values. No partial result is ever presented.

Decomposition:
- Shared package adder_pkg:
  - state encoding constants (S_IDLE, S_RUN, S_DONE)
  - clog2 function used for idx width
- One sub-module: the existing full_adder, instantiated once with #(.WIDTH(WIDTH)).
- Slice mux, carry register and FSM stay in this block.

Test Plan:
1. WIDTH=4, CHUNKS=4, in_a=16'h1234, in_b=16'h1111, in_cin=0. Required: out_sum=16'h2345, out_cout=0, out_valid high exactly 4 edges after accept.
2. in_a=16'hFFFF, in_b=16'h0001, in_cin=0. Required: out_sum=16'h0000, out_cout=1. Checks carry propagation through every slice boundary.
3. in_a=16'hFFFF, in_b=16'hFFFF, in_cin=1. Required: out_sum=16'hFFFF, out_cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
   - Required: out_valid, out_sum and out_cout stable; in_ready=0; no capture.
   - After out_ready=1: IDLE next cycle, then the new operands are accepted.
5. Assert rst two cycles into RUN (in_a=16'hABCD). Required: immediately out_valid=0, in_ready=1, out_sum=0, busy=0. After release, 16'h00FF+16'h0001, cin=0 returns 16'h0100, cout=0.
6. Build with CHUNKS=1, WIDTH=4: in_a=4'hF, in_b=4'h1, in_cin=1. Required: out_sum=4'h1, out_cout=1, out_valid one edge after accept.
